// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request FSM that feeds the IF/ID register.
// A one-entry skid buffer catches a returning word while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush_branch,
    input  logic        flush_jump,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        drop_q, drop_d;
    logic [31:0] skid_q, skid_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;

    logic        redirect;
    logic [31:0] target_pc;
    logic        req_valid;
    logic        accept;
    logic        id_free;
    logic        deliver;
    logic [31:0] deliver_pc;
    logic [31:0] deliver_instr;

    always_comb begin
        redirect      = flush_branch | flush_jump;
        target_pc     = redirect_pc & ~32'h0000_0003;
        req_valid     = (state_q == S_REQ) && !stall_if && !redirect;
        accept        = req_valid && imem_req_ready;
        id_free       = !id_valid_q || !stall_id;

        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        drop_d        = drop_q;
        skid_d        = skid_q;
        deliver       = 1'b0;
        deliver_pc    = inflight_pc_q;
        deliver_instr = imem_rsp_data;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                pc_d    = redirect ? target_pc : RESET_PC;
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d = target_pc;
                end else if (accept) begin
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + 32'd4;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                // A word arriving in the redirect cycle belongs to the old path, so it is dropped here too.
                if (redirect) begin
                    pc_d = target_pc;
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (id_free) begin
                        deliver = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        skid_d  = imem_rsp_data;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target_pc;
                    state_d = S_REQ;
                end else if (!stall_id) begin
                    deliver       = 1'b1;
                    deliver_instr = skid_q;
                    state_d       = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        if (redirect) begin
            id_valid_d = 1'b0;
        end else if (!(stall_id && id_valid_q)) begin
            if (deliver) begin
                id_valid_d = 1'b1;
                id_pc_d    = deliver_pc;
                id_instr_d = deliver_instr;
            end else begin
                id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'h0000_0000;
            drop_q        <= 1'b0;
            skid_q        <= 32'h0000_0000;
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'h0000_0000;
            id_instr_q    <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            drop_q        <= drop_d;
            skid_q        <= skid_d;
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_instr_q    <= id_instr_d;
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_addr      = pc_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_pc_plus4    = id_pc_q + 32'd4;
    assign id_instr       = id_valid_q ? id_instr_q : NOP_INSTR;

endmodule
